alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice and drives it one bit per clock. It also consumes the slice outputs to build a full-width result. It latches two operands and an ALU control code on a start handshake. It then walks bit 0 to MSB through the slice, ripples the carry through a register, and runs a second pass for set-less-than. It reports result, zero, carry-out, overflow and a one-cycle done pulse.

---
 rtl/alu_serial_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: walks operands LSB to MSB, ripples
// the carry through a register, and runs a second LESS pass for set-less-than.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             slice_src1_o,
  output logic             slice_src2_o,
  output logic             slice_less_o,
  output logic             slice_A_invert_o,
  output logic             slice_B_invert_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_operation_o,
  input  logic             slice_result_i,
  input  logic             slice_cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS1,
    S_PASS2,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_ADD,
    OP_SUB,
    OP_SLT,
    OP_NOR
  } op_t;

  localparam logic [1:0] SL_AND  = 2'b00;
  localparam logic [1:0] SL_OR   = 2'b01;
  localparam logic [1:0] SL_ADD  = 2'b10;
  localparam logic [1:0] SL_LESS = 2'b11;

  // Unlisted control codes fall back to AND.
  function automatic op_t decode_op(input logic [3:0] code);
    op_t op;
    case (code)
      4'b0001: op = OP_OR;
      4'b0010: op = OP_ADD;
      4'b0110: op = OP_SUB;
      4'b0111: op = OP_SLT;
      4'b1100: op = OP_NOR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] result_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             set_q;

  logic accept;
  logic in_pass;
  logic last_bit;
  logic arith;
  logic msb_ovf;

  assign accept   = (state_q == S_IDLE) && start_i;
  assign in_pass  = (state_q == S_PASS1) || (state_q == S_PASS2);
  assign last_bit = (cnt_q == LAST_BIT);
  assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
  assign msb_ovf  = slice_cin_o ^ slice_cout_i;
  assign result_d = {slice_result_i, shift_q[WIDTH-1:1]};

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d           = state_q;
    slice_src1_o      = 1'b0;
    slice_src2_o      = 1'b0;
    slice_less_o      = 1'b0;
    slice_A_invert_o  = 1'b0;
    slice_B_invert_o  = 1'b0;
    slice_cin_o       = 1'b0;
    slice_operation_o = SL_AND;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_PASS1;
      end

      S_PASS1: begin
        slice_src1_o = a_q[cnt_q];
        slice_src2_o = b_q[cnt_q];
        case (op_q)
          OP_OR:  slice_operation_o = SL_OR;
          OP_ADD: slice_operation_o = SL_ADD;
          OP_SUB, OP_SLT: begin
            slice_operation_o = SL_ADD;
            slice_B_invert_o  = 1'b1;
          end
          OP_NOR: begin
            slice_operation_o = SL_AND;
            slice_A_invert_o  = 1'b1;
            slice_B_invert_o  = 1'b1;
          end
          default: slice_operation_o = SL_AND;
        endcase
        // Bit 0 seeds the two's-complement +1 for subtraction; later bits ripple.
        if (cnt_q == '0) slice_cin_o = (op_q == OP_SUB) || (op_q == OP_SLT);
        else             slice_cin_o = carry_q;
        if (last_bit) state_d = (op_q == OP_SLT) ? S_PASS2 : S_DONE;
      end

      S_PASS2: begin
        slice_src1_o      = a_q[cnt_q];
        slice_src2_o      = b_q[cnt_q];
        slice_operation_o = SL_LESS;
        slice_less_o      = (cnt_q == '0) ? set_q : 1'b0;
        if (last_bit) state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      set_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= decode_op(ctrl_i);
      a_q     <= src1_i;
      b_q     <= src2_i;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (in_pass) begin
      shift_q <= result_d;
      cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
      if (state_q == S_PASS1) begin
        carry_q <= slice_cout_i;
        if (last_bit) set_q <= slice_result_i ^ msb_ovf;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      busy_o <= (state_d == S_PASS1) || (state_d == S_PASS2);
      done_o <= (state_d == S_DONE);
      // Flags come from the MSB of the arithmetic pass, even when SLT continues.
      if ((state_q == S_PASS1) && last_bit) begin
        cout_o     <= arith & slice_cout_i;
        overflow_o <= arith & msb_ovf;
      end
      if (in_pass && last_bit && (state_d == S_DONE)) begin
        result_o <= result_d;
        zero_o   <= (result_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: a behavioural 1-bit slice closes the loop, and an
// arithmetic model predicts done/busy timing and the final result and flags.
module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic             clk_i   = 1'b0;
  logic             rst_i   = 1'b1;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] src1_i  = '0;
  logic [WIDTH-1:0] src2_i  = '0;
  logic [3:0]       ctrl_i  = 4'b0000;

  logic             slice_src1_o, slice_src2_o, slice_less_o;
  logic             slice_A_invert_o, slice_B_invert_o, slice_cin_o;
  logic [1:0]       slice_operation_o;
  logic             slice_result_i, slice_cout_i;
  logic             busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [WIDTH-1:0] result_o;
  logic [7:0]       slice_bus;

  int n_checks = 0;
  int n_errors = 0;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .src1_i            (src1_i),
    .src2_i            (src2_i),
    .ctrl_i            (ctrl_i),
    .slice_src1_o      (slice_src1_o),
    .slice_src2_o      (slice_src2_o),
    .slice_less_o      (slice_less_o),
    .slice_A_invert_o  (slice_A_invert_o),
    .slice_B_invert_o  (slice_B_invert_o),
    .slice_cin_o       (slice_cin_o),
    .slice_operation_o (slice_operation_o),
    .slice_result_i    (slice_result_i),
    .slice_cout_i      (slice_cout_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .result_o          (result_o),
    .zero_o            (zero_o),
    .cout_o            (cout_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  assign slice_bus = {slice_src1_o, slice_src2_o, slice_less_o, slice_A_invert_o,
                      slice_B_invert_o, slice_cin_o, slice_operation_o};

  // 1-bit ALU slice the sequencer drives.
  always_comb begin
    logic a, b;
    a = slice_src1_o ^ slice_A_invert_o;
    b = slice_src2_o ^ slice_B_invert_o;
    slice_cout_i = (a & b) | (a & slice_cin_o) | (b & slice_cin_o);
    case (slice_operation_o)
      2'b00:   slice_result_i = a & b;
      2'b01:   slice_result_i = a | b;
      2'b10:   slice_result_i = a ^ b ^ slice_cin_o;
      default: slice_result_i = slice_less_o;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             cout;
    logic             ovf;
  } exp_t;

  function automatic exp_t golden(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    exp_t r;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] d;
    r.res  = a & b;
    r.cout = 1'b0;
    r.ovf  = 1'b0;
    case (c)
      C_OR:  r.res = a | b;
      C_NOR: r.res = ~(a | b);
      C_ADD: begin
        s      = {1'b0, a} + {1'b0, b};
        r.res  = s[WIDTH-1:0];
        r.cout = s[WIDTH];
        r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.res[WIDTH-1] != a[WIDTH-1]);
      end
      C_SUB, C_SLT: begin
        s      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        d      = s[WIDTH-1:0];
        r.cout = s[WIDTH];
        r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
        if (c == C_SLT) r.res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
        else            r.res = d;
      end
      default: r.res = a & b;
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  // Transaction-level model: accept when idle, finish W or 2W edges later,
  // then one DONE cycle during which a new start is not yet taken.
  int   edge_no      = 0;
  int   m_done_edge  = 0;
  int   m_ready_edge = 0;
  bit   m_active     = 1'b0;
  bit   m_done_now   = 1'b0;
  exp_t m_cur, m_next;

  initial begin
    m_cur = '{res: '0, zero: 1'b0, cout: 1'b0, ovf: 1'b0};
    m_next = m_cur;
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
        m_active     = 1'b0;
        m_done_now   = 1'b0;
        m_ready_edge = 0;
        m_cur        = '{res: '0, zero: 1'b0, cout: 1'b0, ovf: 1'b0};
      end else begin
        edge_no++;
        m_done_now = 1'b0;
        if (m_active && edge_no == m_done_edge) begin
          m_active     = 1'b0;
          m_done_now   = 1'b1;
          m_cur        = m_next;
          m_ready_edge = edge_no + 2;
        end else if (!m_active && start_i && edge_no >= m_ready_edge) begin
          m_active    = 1'b1;
          m_next      = golden(ctrl_i, src1_i, src2_i);
          m_done_edge = edge_no + ((ctrl_i == C_SLT) ? 2 * WIDTH : WIDTH);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      check("done_o", done_o, m_done_now);
      check("busy_o", busy_o, m_active);
      if (!m_active) begin
        check("result_o", result_o, m_cur.res);
        check("zero_o", zero_o, m_cur.zero);
        check("cout_o", cout_o, m_cur.cout);
        check("overflow_o", overflow_o, m_cur.ovf);
        check("slice idle", slice_bus, 8'h00);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic launch(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk_i);
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Counts edges from the current cycle until done_o is seen, bounded.
  task automatic wait_done(input string name, input int exp_n);
    int n = 0;
    while (1) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (done_o === 1'b1 || n >= 3 * WIDTH) break;
    end
    check({name, " latency"}, n, exp_n);
  endtask

  task automatic check_res(input string name, input logic [WIDTH-1:0] r, input logic z,
                           input logic c, input logic o);
    check({name, " result"}, result_o, r);
    check({name, " zero"}, zero_o, z);
    check({name, " cout"}, cout_o, c);
    check({name, " ovf"}, overflow_o, o);
  endtask

  initial begin
    int n;
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset busy", busy_o, 1'b0);
    check("reset done", done_o, 1'b0);
    check_res("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_i = 1'b1;

    launch(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done("add_ovf", WIDTH);
    check_res("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    launch(C_SUB, 32'h0000_0005, 32'h0000_0005);
    wait_done("sub_zero", WIDTH);
    check_res("sub_zero", 32'h0, 1'b1, 1'b1, 1'b0);

    launch(C_SUB, 32'h8000_0000, 32'h0000_0001);
    wait_done("sub_ovf", WIDTH);
    check_res("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

    launch(C_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done("slt_neg", 2 * WIDTH);
    check_res("slt_neg", 32'h1, 1'b0, 1'b1, 1'b0);

    launch(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_done("slt_ovf", 2 * WIDTH);
    check_res("slt_ovf", 32'h0, 1'b1, 1'b0, 1'b1);

    launch(C_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    wait_done("and", WIDTH);
    check_res("and", 32'h00F0_A5A5, 1'b0, 1'b0, 1'b0);

    launch(C_OR, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    wait_done("or", WIDTH);
    check_res("or", 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0);

    launch(C_NOR, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    wait_done("nor", WIDTH);
    check_res("nor", 32'h000F_0000, 1'b0, 1'b0, 1'b0);

    launch(4'b0011, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
    wait_done("undef_as_and", WIDTH);
    check_res("undef_as_and", 32'h00F0_A5A5, 1'b0, 1'b0, 1'b0);

    // Start raised during the DONE cycle is taken one cycle later.
    launch(C_ADD, 32'h0000_0003, 32'h0000_0004);
    wait_done("add_small", WIDTH);
    check_res("add_small", 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    ctrl_i  = C_ADD;
    src1_i  = 32'h0000_000A;
    src2_i  = 32'h0000_0014;
    start_i = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (n == 2) start_i = 1'b0;
      if (done_o === 1'b1 || n >= 3 * WIDTH) break;
    end
    start_i = 1'b0;
    check("start_in_done latency", n, WIDTH + 2);
    check_res("start_in_done", 32'h0000_001E, 1'b0, 1'b0, 1'b0);

    // Start and new operands mid-pass must not disturb the running add.
    launch(C_ADD, 32'h1234_5678, 32'h1111_1111);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1;
    ctrl_i  = C_SUB;
    src1_i  = 32'hFFFF_FFFF;
    src2_i  = 32'h0000_0000;
    repeat (2) @(negedge clk_i);
    start_i = 1'b0;
    wait_done("busy_start", WIDTH - 6);
    check_res("busy_start", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk_i);

    // Asynchronous reset while bit 10 is on the slice.
    launch(C_ADD, 32'h0000_1000, 32'h0000_2000);
    repeat (10) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("async busy", busy_o, 1'b0);
    check("async done", done_o, 1'b0);
    check("async slice", slice_bus, 8'h00);
    check_res("async", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;

    launch(C_ADD, 32'h0000_FFFF, 32'h0000_0001);
    wait_done("after_reset", WIDTH);
    check_res("after_reset", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
